// File: rtl/psum_writeback.sv
// Partial-sum writeback stage: buffers PE-array results in a small FIFO and
// streams them into the output scratchpad from the z base address, with optional ReLU.
module psum_writeback #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int RELU       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] z_adr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_L = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W:0]   total_reg;
  logic [ADDR_W:0]   acc_cnt_reg, acc_cnt_next;
  logic [ADDR_W:0]   wr_cnt_reg, wr_cnt_next;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    occ_reg;

  logic              mem_we_reg, busy_reg, done_reg;
  logic [ADDR_W-1:0] mem_adr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic              fifo_empty, fifo_full, active;
  logic              accept, bypass, fifo_push, fifo_pop, wr_fire;
  logic [DATA_W-1:0] wr_src;

  function automatic logic [DATA_W-1:0] apply_relu(input logic [DATA_W-1:0] d);
    if (RELU != 0 && d[DATA_W-1]) return '0;
    return d;
  endfunction

  assign fifo_empty = (occ_reg == '0);
  assign fifo_full  = (occ_reg == DEPTH_L);
  assign active     = (state_reg == RUN) || (state_reg == DRAIN);

  assign in_ready = (state_reg == RUN) && !fifo_full && (acc_cnt_reg < total_reg);
  assign accept   = in_valid && in_ready;

  // An accept into an empty FIFO goes straight to the write register,
  // which gives the one-cycle accept-to-write latency.
  assign bypass    = accept && fifo_empty;
  assign fifo_push = accept && !fifo_empty;
  assign fifo_pop  = active && !fifo_empty;
  assign wr_fire   = fifo_pop || bypass;
  assign wr_src    = fifo_empty ? in_data : fifo_mem[rd_ptr_reg];

  assign acc_cnt_next = acc_cnt_reg + {{ADDR_W{1'b0}}, accept};
  assign wr_cnt_next  = wr_cnt_reg + {{ADDR_W{1'b0}}, wr_fire};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (count == '0) ? FINISH : RUN;
      end
      RUN: begin
        if (wr_cnt_next == total_reg)       state_next = FINISH;
        else if (acc_cnt_next == total_reg) state_next = DRAIN;
      end
      DRAIN: begin
        if (wr_cnt_next == total_reg) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      total_reg     <= '0;
      acc_cnt_reg   <= '0;
      wr_cnt_reg    <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      occ_reg       <= '0;
      mem_we_reg    <= 1'b0;
      mem_adr_reg   <= '0;
      mem_wdata_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        if (start) begin
          base_reg    <= z_adr;
          total_reg   <= count;
          acc_cnt_reg <= '0;
          wr_cnt_reg  <= '0;
        end
      end else begin
        acc_cnt_reg <= acc_cnt_next;
        wr_cnt_reg  <= wr_cnt_next;
      end

      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (fifo_push && !fifo_pop)      occ_reg <= occ_reg + 1'b1;
      else if (fifo_pop && !fifo_push) occ_reg <= occ_reg - 1'b1;

      mem_we_reg <= wr_fire;
      if (wr_fire) begin
        mem_adr_reg   <= base_reg + wr_cnt_reg[ADDR_W-1:0];
        mem_wdata_reg <= apply_relu(wr_src);
      end

      busy_reg <= (state_next == RUN) || (state_next == DRAIN);
      done_reg <= (state_reg == FINISH);
    end
  end

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_reg] <= in_data;
  end

  assign mem_we    = mem_we_reg;
  assign mem_adr   = mem_adr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_psum_writeback.sv
// Scoreboard bench for psum_writeback: one instance with ReLU, one without,
// sharing the same stimulus.
module tb_psum_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  z_adr = '0;
  logic [7:0]  count = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;

  logic        in_ready, mem_we, busy, done;
  logic [6:0]  mem_adr;
  logic [15:0] mem_wdata;
  logic        in_ready_nr, mem_we_nr, busy_nr, done_nr;
  logic [6:0]  mem_adr_nr;
  logic [15:0] mem_wdata_nr;

  psum_writeback #(.DATA_W(16), .ADDR_W(7), .FIFO_DEPTH(4), .RELU(1)) dut (
    .clk(clk), .rst(rst), .start(start), .z_adr(z_adr), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done));

  psum_writeback #(.DATA_W(16), .ADDR_W(7), .FIFO_DEPTH(4), .RELU(0)) dut_nr (
    .clk(clk), .rst(rst), .start(start), .z_adr(z_adr), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_nr),
    .mem_we(mem_we_nr), .mem_adr(mem_adr_nr), .mem_wdata(mem_wdata_nr),
    .busy(busy_nr), .done(done_nr));

  always #5 clk = ~clk;

  int checks_total = 0;
  int checks_passed = 0;
  logic [22:0] sb_relu[$];
  logic [22:0] sb_raw[$];
  logic [15:0] stim_q[$];
  bit          vpat_q[$];
  logic [6:0]  exp_base = '0;
  int          acc_idx = 0;
  int          writes_seen = 0;

  function automatic logic [15:0] relu_model(input logic [15:0] d);
    return d[15] ? 16'h0000 : d;
  endfunction

  // Scoreboard: push on accept, pop on each memory write.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        logic [6:0] a;
        a = exp_base + 7'(acc_idx);
        sb_relu.push_back({a, relu_model(in_data)});
        sb_raw.push_back({a, in_data});
        acc_idx++;
      end
      if (mem_we) begin
        logic [22:0] e;
        writes_seen++;
        checks_total++;
        if (sb_relu.size() == 0) begin
          $display("FAIL relu_write unexpected: adr=%0d data=%h, required no write", mem_adr, mem_wdata);
        end else begin
          e = sb_relu.pop_front();
          if ({mem_adr, mem_wdata} !== e)
            $display("FAIL relu_write: adr=%0d data=%h, required adr=%0d data=%h", mem_adr, mem_wdata, e[22:16], e[15:0]);
          else begin
            checks_passed++;
            $display("write adr=%0d data=%h", mem_adr, mem_wdata);
          end
        end
      end
      if (mem_we_nr) begin
        logic [22:0] e;
        checks_total++;
        if (sb_raw.size() == 0) begin
          $display("FAIL raw_write unexpected: adr=%0d data=%h, required no write", mem_adr_nr, mem_wdata_nr);
        end else begin
          e = sb_raw.pop_front();
          if ({mem_adr_nr, mem_wdata_nr} !== e)
            $display("FAIL raw_write: adr=%0d data=%h, required adr=%0d data=%h", mem_adr_nr, mem_wdata_nr, e[22:16], e[15:0]);
          else begin
            checks_passed++;
            $display("raw write adr=%0d data=%h", mem_adr_nr, mem_wdata_nr);
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [6:0] b, input logic [7:0] c);
    exp_base = b; acc_idx = 0; writes_seen = 0;
    z_adr = b; count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_stim();
    int guard = 0;
    while (stim_q.size() > 0) begin
      in_valid = (vpat_q.size() > 0) ? vpat_q.pop_front() : 1'b1;
      in_data = stim_q[0];
      @(negedge clk);
      if (in_valid && in_ready) void'(stim_q.pop_front());
      @(posedge clk); #1;
      guard++;
      if (guard > 200) begin
        checks_total++;
        $display("FAIL drive_timeout: %0d words unaccepted, required 0", stim_q.size());
        stim_q.delete();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int guard = 0;
    bit seen = 0;
    while (guard < 60 && !seen) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      guard++;
    end
    checks_total++;
    if (!seen) $display("FAIL %s_done: done=0 within 60 cycles, required 1", tag);
    else checks_passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks_total++;
    if ({in_ready, mem_we, mem_adr, mem_wdata, busy, done} !== 26'd0)
      $display("FAIL reset_outputs: %h, required 0", {in_ready, mem_we, mem_adr, mem_wdata, busy, done});
    else checks_passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] vals [4];
    vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30; vals[3] = 16'd40;
    pulse_start(7'd15, 8'd4);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = vals[k];
      @(negedge clk);
      checks_total++;
      if ({in_ready, busy, mem_we} !== {1'b1, 1'b1, (k > 0)})
        $display("FAIL basic_cycle%0d: ready/busy/we=%b, required %b", k, {in_ready, busy, mem_we}, {1'b1, 1'b1, (k > 0)});
      else checks_passed++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks_total++;
    if ({mem_we, done, in_ready} !== 3'b100)
      $display("FAIL basic_last_write: we/done/ready=%b, required 100", {mem_we, done, in_ready});
    else checks_passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks_total++;
    if ({done, mem_we, busy} !== 3'b100)
      $display("FAIL basic_done: done/we/busy=%b, required 100", {done, mem_we, busy});
    else checks_passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks_total++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse: done=%b, required 0", done);
    else checks_passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_relu();
    pulse_start(7'd40, 8'd4);
    stim_q = '{16'h0005, 16'hFFFB, 16'h0000, 16'h8000};
    drive_stim();
    wait_done("relu");
  endtask

  task automatic test_wrap();
    pulse_start(7'd126, 8'd4);
    stim_q = '{16'd100, 16'd200, 16'd300, 16'd400};
    drive_stim();
    wait_done("wrap");
  endtask

  task automatic test_back_to_back_bursty();
    int guard = 0;
    bit ready_seen = 0;
    pulse_start(7'd50, 8'd8);
    stim_q = '{16'd1, 16'hFFFF, 16'd3, 16'd4, 16'h8001, 16'd6, 16'd7, 16'h7FFF};
    vpat_q = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    drive_stim();
    vpat_q.delete();
    in_valid = 1'b1;
    while (guard < 30) begin
      @(negedge clk);
      if (in_ready) ready_seen = 1;
      guard++;
      if (done) guard = 30;
    end
    in_valid = 1'b0;
    checks_total++;
    if (ready_seen) $display("FAIL bursty_ready_after_last: in_ready=1, required 0");
    else checks_passed++;
    checks_total++;
    if (writes_seen !== 8) $display("FAIL bursty_write_count: %0d, required 8", writes_seen);
    else checks_passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_count();
    pulse_start(7'd10, 8'd0);
    @(negedge clk);
    checks_total++;
    if ({done, busy, mem_we} !== 3'b000)
      $display("FAIL zero_first: done/busy/we=%b, required 000", {done, busy, mem_we});
    else checks_passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks_total++;
    if ({done, busy, mem_we} !== 3'b100)
      $display("FAIL zero_done: done/busy/we=%b, required 100", {done, busy, mem_we});
    else checks_passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks_total++;
    if ({done, writes_seen} !== {1'b0, 32'd0})
      $display("FAIL zero_after: done=%b writes=%0d, required 0 and 0", done, writes_seen);
    else checks_passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_job();
    bit done_seen = 0;
    pulse_start(7'd20, 8'd6);
    stim_q = '{16'd11, 16'd12, 16'd13};
    drive_stim();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks_total++;
    if ({mem_we, busy, in_ready} !== 3'b000)
      $display("FAIL midrst_outputs: we/busy/ready=%b, required 000", {mem_we, busy, in_ready});
    else checks_passed++;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    checks_total++;
    if (done_seen || writes_seen != 3)
      $display("FAIL midrst_nodone: done_seen=%0d writes=%0d, required 0 and 3", done_seen, writes_seen);
    else checks_passed++;
    checks_total++;
    if (sb_relu.size() != 0) $display("FAIL midrst_pending: %0d, required 0", sb_relu.size());
    else checks_passed++;
    sb_relu.delete(); sb_raw.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    pulse_start(7'd0, 8'd2);
    stim_q = '{16'd7, 16'd8};
    drive_stim();
    wait_done("midrst_next");
    checks_total++;
    if (writes_seen != 2) $display("FAIL midrst_next_count: %0d, required 2", writes_seen);
    else checks_passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_wrap();
    test_back_to_back_bursty();
    test_zero_count();
    test_reset_mid_job();
    repeat (3) @(posedge clk);
    #1;
    checks_total++;
    if (sb_relu.size() + sb_raw.size() != 0)
      $display("FAIL final_scoreboard: %0d pending, required 0", sb_relu.size() + sb_raw.size());
    else checks_passed++;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/psum_writeback.md
Name: psum_writeback

Overview:
- Downstream stage of the convolution top level.
- Accepts partial-sum results from the PE array through a valid/ready handshake and buffers them in a small FIFO.
- Writes the results one per cycle into the output scratchpad, starting at the z base address, with optional ReLU.
- Pulses done after the last programmed word has been committed to memory.

Parameters:
- DATA_W, 16, width of each psum word and of the memory write data.
- ADDR_W, 7, output memory address width; matches the 7-bit z address.
- FIFO_DEPTH, 4, entries in the internal buffer; must be a power of two, at least 2.
- RELU, 1, when 1 negative psums (signed) are written as 0; when 0 data passes unchanged.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches z_adr and count, begins a job.
- z_adr  in  ADDR_W  base address of the output region.
- count  in  ADDR_W+1  number of words to write, 0..128.
- in_valid  in  1  upstream psum valid.
- in_data  in  DATA_W  upstream psum, signed two's complement.
- in_ready  out  1  block can accept in_data this cycle.
- mem_we  out  1  output memory write enable.
- mem_adr  out  ADDR_W  output memory write address.
- mem_wdata  out  DATA_W  output memory write data.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the job completes.

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO empty, all counters 0. Outputs in_ready=0, mem_we=0, mem_adr=0, mem_wdata=0, busy=0, done=0.
- FSM states: IDLE, RUN, DRAIN, FINISH.
- IDLE: on start=1, latch base=z_adr and total=count, clear counters acc_cnt and wr_cnt.
  - If count=0, go to FINISH.
  - Otherwise go to RUN.
  - start is ignored in every state other than IDLE.
- RUN: in_ready = (FIFO not full) and (acc_cnt < total), driven combinationally from registered state.
  - A transfer occurs when in_valid and in_ready are both high; the word is pushed into the FIFO and acc_cnt increments.
  - When acc_cnt reaches total, go to DRAIN; in_ready=0 from that cycle onward.
- Write port, active in RUN and DRAIN:
  - Each cycle the FIFO is non-empty, pop one entry and register mem_we=1, mem_adr=(base+wr_cnt) mod 2^ADDR_W, mem_wdata=relu(entry). Then wr_cnt increments.
  - Write latency is one cycle: a word accepted in cycle N into an empty FIFO appears on the memory port in cycle N+1.
  - Sustained throughput is 1 word/cycle.
  - Otherwise mem_we=0, and mem_adr/mem_wdata hold their last values.
- Simultaneous push and pop on a full FIFO is not allowed, because in_ready is low when full. Push and pop in the same cycle on a non-full, non-empty FIFO keeps occupancy unchanged.
- DRAIN: when wr_cnt reaches total (the last write is registered), go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, then return to IDLE. A start in the FINISH cycle is ignored.
- busy=1 in RUN and DRAIN only.
- Address wrap: base+wr_cnt overflowing 2^ADDR_W wraps to 0. Example: base 127, second word goes to address 0.
- RELU: a negative value (MSB=1) becomes 0. Zero and positive values pass unchanged.
- Reset asserted mid-job:
  - Immediate return to IDLE.
  - FIFO contents discarded; no further writes.
  - done is not pulsed.
- in_valid while in IDLE or FINISH is ignored (in_ready=0).

Test Plan:
- Basic job: start with z_adr=15, count=4, inputs 10,20,30,40 back-to-back with in_valid=1 -> writes to addresses 15,16,17,18 with data 10,20,30,40 on consecutive cycles, first write one cycle after the first accept; done pulses once, one cycle after the last write.
- ReLU check with RELU=1: inputs 0x0005, 0xFFFB (-5), 0x0000, 0x8000 -> written 5, 0, 0, 0; with RELU=0 -> written 5, 0xFFFB, 0, 0x8000.
- Address wrap: z_adr=126, count=4 -> writes at 126, 127, 0, 1.
- Backpressure and bursty input: count=8, in_valid toggled 1,0,1,1,0,1,1,1,1,1 -> exactly 8 writes in order with no duplicates or drops; in_ready never high after the 8th accept; FIFO never exceeds FIFO_DEPTH.
- Zero count: start with count=0 -> no mem_we; done pulses 2 cycles after start; busy stays 0.
- Reset mid-job: count=6, assert rst after 3 writes -> mem_we=0 immediately, no done pulse. A following job with z_adr=0, count=2 then writes addresses 0 and 1 correctly.
